// File: rtl/impulse_memory.sv
// impulse_memory: four-bank impulse-response store with an 8-lane tap read server.
// Build option: define IMPULSE_REVERSE_EN to store the response time-reversed.
module impulse_memory #(
  parameter int IMPULSE_LENGTH = 24000
) (
  input  logic                    audio_clk,
  input  logic                    rst_in,
  input  logic                    load_start,
  input  logic signed [15:0]      ir_sample_in,
  input  logic                    ir_sample_valid,
  input  logic [11:0]             first_ir_index,
  input  logic [11:0]             second_ir_index,
  output logic signed [7:0][15:0] ir_vals,
  output logic                    impulse_in_memory_complete,
  output logic [15:0]             taps_loaded
);
  localparam int BANK_DEPTH = IMPULSE_LENGTH / 4;
  localparam int AW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(BANK_DEPTH - 1);
`ifdef IMPULSE_REVERSE_EN
  localparam logic [1:0]    START_BANK = 2'd3;
  localparam logic [AW-1:0] START_ADDR = ADDR_LAST;
`else
  localparam logic [1:0]    START_BANK = 2'd0;
  localparam logic [AW-1:0] START_ADDR = '0;
`endif

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
  state_t state, state_next;

  logic accept, last_tap;
  logic [1:0] cur_bank, wr_bank;
  logic [AW-1:0] cur_addr, wr_addr;
  logic wr_en;
  logic signed [15:0] wr_data;
  logic done_d1, done_d2;
  logic [AW-1:0] ra, rb;
  logic gate_a, gate_b, gate_a_d, gate_b_d;
  logic signed [3:0][15:0] rd_a_all, rd_b_all;

  always_comb begin
    state_next = state;
    accept = 1'b0;
    last_tap = (32'(taps_loaded) == IMPULSE_LENGTH - 1);
    if (load_start) begin
      state_next = LOADING;
    end else begin
      unique case (state)
        LOADING: begin
          if (ir_sample_valid) begin
            accept = 1'b1;
            if (last_tap) state_next = READY;
          end
        end
        EMPTY, READY: ;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      state <= EMPTY;
      taps_loaded <= '0;
      cur_bank <= START_BANK;
      cur_addr <= START_ADDR;
      wr_en <= 1'b0;
      wr_bank <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      done_d1 <= 1'b0;
      done_d2 <= 1'b0;
      impulse_in_memory_complete <= 1'b0;
    end else begin
      state <= state_next;
      wr_en <= accept;
      done_d1 <= accept && last_tap;
      done_d2 <= done_d1 && !load_start;
      if (load_start) begin
        taps_loaded <= '0;
        cur_bank <= START_BANK;
        cur_addr <= START_ADDR;
        impulse_in_memory_complete <= 1'b0;
      end else begin
        if (done_d2) impulse_in_memory_complete <= 1'b1;
        if (accept) begin
          taps_loaded <= taps_loaded + 16'd1;
          wr_bank <= cur_bank;
          wr_addr <= cur_addr;
          wr_data <= ir_sample_in;
`ifdef IMPULSE_REVERSE_EN
          if (cur_addr == '0) begin
            cur_addr <= ADDR_LAST;
            cur_bank <= cur_bank - 2'd1;
          end else begin
            cur_addr <= cur_addr - 1'b1;
          end
`else
          if (cur_addr == ADDR_LAST) begin
            cur_addr <= '0;
            cur_bank <= cur_bank + 2'd1;
          end else begin
            cur_addr <= cur_addr + 1'b1;
          end
`endif
        end
      end
    end
  end

  // gate is captured with the index so a late load_start cannot corrupt it
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      ra <= '0;
      rb <= '0;
      gate_a <= 1'b0;
      gate_b <= 1'b0;
      gate_a_d <= 1'b0;
      gate_b_d <= 1'b0;
      ir_vals <= '0;
    end else begin
      ra <= AW'(first_ir_index);
      rb <= AW'(second_ir_index);
      gate_a <= impulse_in_memory_complete &&
                ({20'd0, first_ir_index} < 32'(BANK_DEPTH));
      gate_b <= impulse_in_memory_complete &&
                ({20'd0, second_ir_index} < 32'(BANK_DEPTH));
      gate_a_d <= gate_a;
      gate_b_d <= gate_b;
      for (int k = 0; k < 4; k++) begin
        ir_vals[2*k]   <= gate_a_d ? rd_a_all[k] : '0;
        ir_vals[2*k+1] <= gate_b_d ? rd_b_all[k] : '0;
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_bank
    logic signed [15:0] mem [BANK_DEPTH];
    logic signed [15:0] rd_a, rd_b;
    logic [AW-1:0] addr_a;
    assign addr_a = wr_en ? wr_addr : ra;
    always_ff @(posedge audio_clk) begin
      if (wr_en && wr_bank == 2'(k)) mem[addr_a] <= wr_data;
      rd_a <= mem[addr_a];
      rd_b <= mem[rb];
    end
    assign rd_a_all[k] = rd_a;
    assign rd_b_all[k] = rd_b;
  end
endmodule

// File: tb/tb_impulse_memory.sv
// tb_impulse_memory: directed stimulus against a tap-level model of the IR store.
// Honours IMPULSE_REVERSE_EN the same way the design does.
module tb_impulse_memory;
  localparam int L  = 32;
  localparam int BD = L / 4;
`ifdef IMPULSE_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_start = 1'b0;
  logic valid = 1'b0;
  logic signed [15:0] sample = '0;
  logic [11:0] first = '0;
  logic [11:0] second = '0;
  logic signed [7:0][15:0] ir_vals;
  logic complete;
  logic [15:0] taps;
  int total = 0;
  int bad = 0;
  bit en_chk = 1'b0;

  impulse_memory #(.IMPULSE_LENGTH(L)) dut (
    .audio_clk(clk),
    .rst_in(rst),
    .load_start(load_start),
    .ir_sample_in(sample),
    .ir_sample_valid(valid),
    .first_ir_index(first),
    .second_ir_index(second),
    .ir_vals(ir_vals),
    .impulse_in_memory_complete(complete),
    .taps_loaded(taps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // model: tap-indexed contents plus the visible handshake state
  logic signed [15:0] mmem [4][4096];
  int m_taps;
  bit m_loading;
  bit m_complete;
  int m_cnt;
  logic [127:0] exp0, exp1, exp2;

  function automatic logic [127:0] lanes(input logic [11:0] a,
                                         input logic [11:0] b, input bit en);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (en && int'(a) < BD) r[32*k +: 16] = mmem[2'(k)][a];
      if (en && int'(b) < BD) r[32*k+16 +: 16] = mmem[2'(k)][b];
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_taps = 0;
      m_loading = 1'b0;
      m_complete = 1'b0;
      m_cnt = 0;
      exp0 = '0;
      exp1 = '0;
      exp2 = '0;
    end else begin
      int lg;
      exp2 = exp1;
      exp1 = exp0;
      exp0 = lanes(first, second, m_complete);
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_complete = 1'b1;
      end
      if (load_start) begin
        m_taps = 0;
        m_loading = 1'b1;
        m_complete = 1'b0;
        m_cnt = 0;
      end else if (m_loading && valid) begin
        lg = REV ? (L - 1 - m_taps) : m_taps;
        mmem[2'(lg / BD)][12'(lg % BD)] = sample;
        m_taps++;
        if (m_taps == L) begin
          m_loading = 1'b0;
          m_cnt = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en_chk) begin
      chk("ir_vals", ir_vals, exp2);
      chk("complete", 128'(complete), 128'(m_complete));
      chk("taps_loaded", 128'(taps), 128'(m_taps[15:0]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    cyc(1);
    load_start = 1'b0;
  endtask

  task automatic send(input int v, input int gap);
    sample = 16'(v);
    valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    cyc(gap);
  endtask

  task automatic sweep(input int lane0_at7);
    for (int i = 0; i < 8; i++) begin
      first = 12'(i);
      second = 12'(i + 1);
      cyc(1);
    end
    cyc(2);
    chk("sweep_oob_lane1", 128'(ir_vals[1]), 128'(0));
    chk("sweep_lane0_idx7", 128'(ir_vals[0]), 128'(lane0_at7));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][15:0] lit;
    rst = 1'b1;
    cyc(2);
    chk("rst_ir_vals", ir_vals, '0);
    chk("rst_complete", 128'(complete), 128'(0));
    chk("rst_taps", 128'(taps), 128'(0));
    rst = 1'b0;
    en_chk = 1'b1;
    first = 12'd2;
    second = 12'd3;
    cyc(3);
    chk("empty_read_zero", ir_vals, '0);

    pulse_load();
    for (int n = 0; n < L; n++) begin
      sample = 16'(n + 100);
      valid = 1'b1;
      cyc(1);
    end
    valid = 1'b0;
    chk("complete_t0", 128'(complete), 128'(0));
    chk("taps_full", 128'(taps), 128'(L));
    cyc(1);
    chk("complete_t1", 128'(complete), 128'(0));
    cyc(1);
    chk("complete_t2", 128'(complete), 128'(1));
    first = 12'd7;
    second = 12'd0;
    cyc(1);
`ifdef IMPULSE_REVERSE_EN
    first = 12'd0;
    second = 12'd1;
`else
    first = 12'd2;
    second = 12'd3;
`endif
    cyc(2);
    chk("final_tap_lane6", 128'(ir_vals[6]), 128'(REV ? 100 : 131));
    cyc(1);
`ifdef IMPULSE_REVERSE_EN
    chk("rev_lane0", 128'(ir_vals[0]), 128'(131));
    chk("rev_lane1", 128'(ir_vals[1]), 128'(130));
`else
    lit = {16'd127, 16'd126, 16'd119, 16'd118,
           16'd111, 16'd110, 16'd103, 16'd102};
    chk("fwd_read_2_3", ir_vals, lit);
`endif
    sweep(REV ? 124 : 107);

    for (int i = 0; i < 3; i++) begin
      sample = -16'sd1;
      valid = 1'b1;
      cyc(1);
    end
    valid = 1'b0;
    cyc(1);
    chk("ready_ignore_taps", 128'(taps), 128'(L));
    sweep(REV ? 124 : 107);

    first = 12'd2;
    second = 12'd3;
    pulse_load();
    chk("restart_complete_drop", 128'(complete), 128'(0));
    chk("restart_taps_clear", 128'(taps), 128'(0));
    for (int n = 0; n < 11; n++) begin
      send(n + 200, 2);
      chk("gap_taps_step", 128'(taps), 128'(n + 1));
    end
    load_start = 1'b1;
    sample = -16'sd5;
    valid = 1'b1;
    cyc(1);
    load_start = 1'b0;
    valid = 1'b0;
    chk("restart_drop_sample", 128'(taps), 128'(0));
    chk("restart_low", 128'(complete), 128'(0));
    chk("loading_read_zero", ir_vals, '0);
    for (int n = 0; n < L; n++) send(n + 300, 2);
    chk("gap_complete", 128'(complete), 128'(1));
    sweep(REV ? 324 : 307);

    first = 12'd2;
    second = 12'd3;
    cyc(1);
    load_start = 1'b1;
    cyc(1);
    load_start = 1'b0;
    sample = 16'sd400;
    valid = 1'b1;
    cyc(1);
    sample = 16'sd401;
    cyc(1);
    valid = 1'b0;
    chk("inflight_lane0", 128'(ir_vals[0]), 128'(REV ? 329 : 302));
    #2 rst = 1'b1;
    #1;
    chk("async_ir_vals", ir_vals, '0);
    chk("async_complete", 128'(complete), 128'(0));
    chk("async_taps", 128'(taps), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample = 16'(i + 500);
      valid = 1'b1;
      cyc(1);
    end
    valid = 1'b0;
    chk("empty_ignore_taps", 128'(taps), 128'(0));

    pulse_load();
    for (int n = 0; n < L; n++) begin
      sample = 16'(n + 100);
      valid = 1'b1;
      cyc(1);
    end
    valid = 1'b0;
    cyc(2);
    chk("reload_complete", 128'(complete), 128'(1));
    sweep(REV ? 124 : 107);
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
